alu_8bit: RTL and testbench

Registered 8-bit arithmetic/logic unit with eight operations selected by a 3-bit opcode. It produces the result plus Zero and Carry flags. It sits in the datapath as a single-cycle-latency execution stage. Operands are sampled when in_valid is high, and the registered result is presented with out_valid one clock later.

---
 rtl/alu_8bit_if.sv | 29 ++
 rtl/alu_8bit.sv | 91 +++++++++
 tb/tb_alu_8bit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_8bit_if.sv
// Purpose : operand/result bundle for the registered ALU stage.
// Latency : n/a (wires only); the ALU adds one register stage.
// Backpr. : none; the master may assert in_valid every cycle.
// Ports   : in_valid/A/B/Opcode flow master->slave,
//           Result/Zero/Carry/out_valid flow slave->master.
interface alu_8bit_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       Opcode;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Carry;
  logic             out_valid;

  // Issuer of operations (datapath front end / testbench).
  modport master (
    output in_valid, A, B, Opcode,
    input  Result, Zero, Carry, out_valid
  );

  // The ALU itself.
  modport slave (
    input  in_valid, A, B, Opcode,
    output Result, Zero, Carry, out_valid
  );
endinterface

// File: rtl/alu_8bit.sv
// Purpose : registered 8-op ALU (ADD/SUB/AND/OR/XOR/NOT/SHL/SHR) with Zero/Carry.
// Latency : 1 cycle from in_valid to out_valid/Result/Zero/Carry.
// Backpr. : none; accepts an operation every cycle, never stalls.
// Ports   : clk, rst (sync, active-high), bus (alu_8bit_if.slave).
module alu_8bit #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  alu_8bit_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  logic [WIDTH-1:0] result_d, result_q;
  logic             carry_d,  carry_q;
  logic             zero_q;
  logic             valid_q;

  // One extra bit on add/sub: for SUB the top bit of the wrapped
  // difference is exactly the unsigned borrow (A < B).
  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;

  assign sum_ext  = {1'b0, bus.A} + {1'b0, bus.B};
  assign diff_ext = {1'b0, bus.A} - {1'b0, bus.B};

  always_comb begin
    result_d = '0;
    carry_d  = 1'b0;
    case (op_e'(bus.Opcode))
      OP_ADD: begin
        result_d = sum_ext[WIDTH-1:0];
        carry_d  = sum_ext[WIDTH];
      end
      OP_SUB: begin
        result_d = diff_ext[WIDTH-1:0];
        carry_d  = diff_ext[WIDTH];
      end
      OP_AND: result_d = bus.A & bus.B;
      OP_OR:  result_d = bus.A | bus.B;
      OP_XOR: result_d = bus.A ^ bus.B;
      OP_NOT: result_d = ~bus.A;
      OP_SHL: begin
        result_d = {bus.A[WIDTH-2:0], 1'b0};
        carry_d  = bus.A[WIDTH-1];
      end
      OP_SHR: begin
        result_d = {1'b0, bus.A[WIDTH-1:1]};
        carry_d  = bus.A[0];
      end
      default: begin
        result_d = '0;
        carry_d  = 1'b0;
      end
    endcase
  end

  // Result/flags only load on an accepted op so idle cycles hold the last
  // answer; valid follows in_valid every cycle so it pulses once per op.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        result_q <= result_d;
        zero_q   <= (result_d == '0);
        carry_q  <= carry_d;
      end
    end
  end

  assign bus.Result    = result_q;
  assign bus.Zero      = zero_q;
  assign bus.Carry     = carry_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_alu_8bit.sv
// Purpose : self-checking bench for alu_8bit: directed plan vectors + random ops.
// Latency : checks each output 1 ns after the edge that registered it.
// Backpr. : n/a; drives one op (or idle/reset) per cycle.
module tb_alu_8bit;

  logic clk;
  logic rst;

  alu_8bit_if #(.WIDTH(8)) bus ();

  alu_8bit #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference expectation carried between steps (used for hold checks).
  logic [7:0] m_res;
  logic       m_z;
  logic       m_c;

  // Behavioural model from the opcode table, in plain integer arithmetic.
  task automatic ref_model(input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, output logic [7:0] res,
                           output logic c);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    r  = 0;
    c  = 1'b0;
    case (op)
      3'd0: begin r = ia + ib;        c = (r > 255);   end
      3'd1: begin r = ia - ib + 256;  c = (ia < ib);   end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = 255 - ia;
      3'd6: begin r = ia * 2;         c = (ia >= 128); end
      default: begin r = ia / 2;      c = (ia % 2 == 1); end
    endcase
    res = 8'(r % 256);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) passes++;
    else $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp_v);
  endtask

  // Drive one cycle at the falling edge, then check all outputs just after
  // the following rising edge against the supplied expectation.
  task automatic step(input logic r, input logic v, input logic [2:0] op,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] er, input logic ez, input logic ec,
                      input logic ev, input string tag);
    @(negedge clk);
    rst          = r;
    bus.in_valid = v;
    bus.Opcode   = op;
    bus.A        = a;
    bus.B        = b;
    @(posedge clk);
    #1;
    chk({tag, ".res"}, bus.Result, er);
    chk({tag, ".z"},   {7'd0, bus.Zero},      {7'd0, ez});
    chk({tag, ".c"},   {7'd0, bus.Carry},     {7'd0, ec});
    chk({tag, ".vld"}, {7'd0, bus.out_valid}, {7'd0, ev});
    m_res = er;
    m_z   = ez;
    m_c   = ec;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
    logic       c;
    string      tag;
  } vec_t;

  vec_t plan [17];

  initial begin
    plan[0]  = '{3'd0, 8'h0C, 8'h05, 8'h11, 1'b0, 1'b0, "add_0c_05"};
    plan[1]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, "add_ff_01"};
    plan[2]  = '{3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, "add_00_00"};
    plan[3]  = '{3'd1, 8'h0C, 8'h05, 8'h07, 1'b0, 1'b0, "sub_0c_05"};
    plan[4]  = '{3'd1, 8'h05, 8'h0C, 8'hF9, 1'b0, 1'b1, "sub_05_0c"};
    plan[5]  = '{3'd1, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0, "sub_33_33"};
    plan[6]  = '{3'd2, 8'hCC, 8'hAA, 8'h88, 1'b0, 1'b0, "and_cc_aa"};
    plan[7]  = '{3'd3, 8'hCC, 8'hAA, 8'hEE, 1'b0, 1'b0, "or_cc_aa"};
    plan[8]  = '{3'd4, 8'hCC, 8'hAA, 8'h66, 1'b0, 1'b0, "xor_cc_aa"};
    plan[9]  = '{3'd5, 8'hCC, 8'hAA, 8'h33, 1'b0, 1'b0, "not_cc"};
    plan[10] = '{3'd2, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, "and_f0_0f"};
    plan[11] = '{3'd6, 8'h0C, 8'h5A, 8'h18, 1'b0, 1'b0, "shl_0c"};
    plan[12] = '{3'd7, 8'h0C, 8'hA5, 8'h06, 1'b0, 1'b0, "shr_0c"};
    plan[13] = '{3'd6, 8'h80, 8'hFF, 8'h00, 1'b1, 1'b1, "shl_80"};
    plan[14] = '{3'd7, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b1, "shr_01"};
    plan[15] = '{3'd6, 8'hC1, 8'h00, 8'h82, 1'b0, 1'b1, "shl_c1"};
    plan[16] = '{3'd7, 8'h82, 8'h00, 8'h41, 1'b0, 1'b0, "shr_82"};
  end

  // Watchdog: the run is clock-driven only, but never let it hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passes);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] r_res;
    logic       r_c;
    logic       r_rst, r_v;
    logic [2:0] r_op;
    logic [7:0] r_a, r_b;

    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.Opcode   = 3'd0;
    bus.A        = 8'hFF;
    bus.B        = 8'h01;
    m_res = 8'h00; m_z = 1'b0; m_c = 1'b0;

    // Reset held two cycles with a live ADD on the inputs: rst wins.
    step(1'b1, 1'b1, 3'd0, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, "rst_cyc1");
    step(1'b1, 1'b1, 3'd0, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, "rst_cyc2");

    // Directed plan vectors, issued back to back; constants are checked,
    // and the reference model is cross-checked against the same constants.
    foreach (plan[i]) begin
      ref_model(plan[i].op, plan[i].a, plan[i].b, r_res, r_c);
      chk({plan[i].tag, ".model"}, {r_c, 7'd0} ^ r_res, {plan[i].c, 7'd0} ^ plan[i].res);
      step(1'b0, 1'b1, plan[i].op, plan[i].a, plan[i].b,
           plan[i].res, plan[i].z, plan[i].c, 1'b1, plan[i].tag);
    end

    // Three consecutive accepted ops -> three consecutive valid pulses.
    step(1'b0, 1'b1, 3'd0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b1, "b2b_1");
    step(1'b0, 1'b1, 3'd1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b1, 1'b1, "b2b_2");
    step(1'b0, 1'b1, 3'd4, 8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b1, "b2b_3");

    // Idle gap with garbage on the operands: valid drops, outputs hold.
    step(1'b0, 1'b0, 3'd0, 8'hFF, 8'hFF, m_res, m_z, m_c, 1'b0, "gap_1");
    step(1'b0, 1'b0, 3'd6, 8'h81, 8'h00, m_res, m_z, m_c, 1'b0, "gap_2");

    // Accept an op, then reset on the very next cycle while still valid.
    step(1'b0, 1'b1, 3'd0, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b1, 1'b1, "pre_rst");
    step(1'b1, 1'b1, 3'd0, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, "mid_rst");
    step(1'b0, 1'b0, 3'd0, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, "post_rst");

    // Random ops, idles and occasional resets against the model.
    for (int n = 0; n < 300; n++) begin
      r_rst = ($urandom_range(0, 24) == 0);
      r_v   = ($urandom_range(0, 3) != 0);
      r_op  = 3'($urandom_range(0, 7));
      r_a   = 8'($urandom_range(0, 255));
      r_b   = 8'($urandom_range(0, 255));
      if (n % 16 == 0) r_b = r_a;   // exercise equal-operand SUB/XOR
      if (r_rst) begin
        step(1'b1, r_v, r_op, r_a, r_b, 8'h00, 1'b0, 1'b0, 1'b0, "rnd_rst");
      end else if (r_v) begin
        ref_model(r_op, r_a, r_b, r_res, r_c);
        step(1'b0, 1'b1, r_op, r_a, r_b, r_res, (r_res == 8'h00), r_c, 1'b1, "rnd_op");
      end else begin
        step(1'b0, 1'b0, r_op, r_a, r_b, m_res, m_z, m_c, 1'b0, "rnd_idle");
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
